eth_udp_pattern_gen: RTL
========================

ETH_UDP_PATTERN_GEN -- requirements
Module: eth_udp_pattern_gen

Interface
REQ-001 Parameter LEN_WIDTH, default 16, width of payload length, byte index and usr_data_len_o.
REQ-002 Parameter GAP_WIDTH, default 16, width of inter-packet gap counter.
REQ-003 Parameter CNT_WIDTH, default 16, width of packet-count limit and sent counter.
REQ-004 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR start value.
REQ-005 clk  in  1  user clock, same domain as PHY user interface; one clock, all logic on rising edge.
REQ-006 reset_i  in  1  reset, synchronous, active-high.
REQ-007 enable_i  in  1  level; run while high.
REQ-008 mode_i  in  2  00 count restarting at 0 per packet; 01 count continuing across packets; 10 LFSR; 11 constant.
REQ-009 const_i  in  8  byte for mode 11.
REQ-010 len_i  in  LEN_WIDTH  payload bytes per packet.
REQ-011 gap_i  in  GAP_WIDTH  idle cycles between packets.
REQ-012 pkt_count_i  in  CNT_WIDTH  packets per run; 0 = unlimited.
REQ-013 seq_hdr_i  in  1  prefix payload with 2-byte sequence number.
REQ-014 usr_clken_i  in  1  PHY accepted current byte.
REQ-015 usr_start_o  out  1  packet request to PHY.
REQ-016 usr_data_o  out  8  current payload byte.
REQ-017 usr_data_len_o  out  LEN_WIDTH  latched payload length.
REQ-018 busy_o, done_o, err_o  out  1 each  running / run complete / sticky protocol error.
REQ-019 pkts_sent_o  out  CNT_WIDTH  packets completed this run.

Function
REQ-020 States IDLE, START, SEND, GAP, DONE; busy_o=1 in START, SEND, GAP.
REQ-021 IDLE: on enable_i=1 and len_i!=0 latch mode, const, len, gap, pkt_count, seq_hdr; clear pkts_sent_o, byte index, sequence number; load LFSR_SEED; go START next cycle. len_i=0 -> remain IDLE.
REQ-022 Configuration inputs are ignored outside IDLE.
REQ-023 START: usr_start_o=1, usr_data_o=byte 0 valid; usr_start_o drops the cycle after first usr_clken_i.
REQ-024 Each usr_clken_i in START/SEND consumes usr_data_o; next byte valid the following cycle.
REQ-025 Byte index 0..len-1; clken at index len-1 completes packet: pkts_sent_o+1, sequence number+1 (wraps at 2^16).
REQ-026 After completion: DONE if pkt_count!=0 and new pkts_sent_o==pkt_count; else IDLE if enable_i=0; else GAP, or START directly if gap=0.
REQ-027 GAP: count gap cycles, then START; enable_i=0 during GAP -> IDLE immediately.
REQ-028 enable_i=0 during START/SEND: current packet finishes, then IDLE.
REQ-029 DONE: done_o=1; return to IDLE when enable_i=0.
REQ-030 seq_hdr=1 and len>=2: bytes 0,1 = sequence number high, low; pattern fills bytes 2..len-1; seq_hdr ignored when len<2.
REQ-031 Mode 00: pattern byte = index-in-pattern mod 256, restarting at 0 each packet. Mode 01: 8-bit counter advancing per pattern byte, persisting across packets in a run.
REQ-032 Mode 10: 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, output current value, advance per pattern byte, persisting across packets.
REQ-033 Mode 11: const_i latched value.
REQ-034 usr_clken_i in IDLE, GAP or DONE sets err_o and is otherwise ignored; err_o cleared only by reset or IDLE->START.
REQ-035 pkts_sent_o saturates at all-ones in unlimited mode.

Reset
REQ-036 reset_i=1 at any time, including mid-packet, forces IDLE next edge: usr_start_o=0, usr_data_o=0, usr_data_len_o=0, busy_o=0, done_o=0, err_o=0, pkts_sent_o=0, LFSR=LFSR_SEED.

Verification
REQ-037 mode 00, len 4, gap 3, count 2, clken every cycle -> bytes 00 01 02 03, 3 idle cycles, 00 01 02 03, done_o=1, pkts_sent_o=2.
REQ-038 mode 01, len 3, count 2 -> 00 01 02 then 03 04 05.
REQ-039 mode 10, seq_hdr 1, len 5, count 2 -> 00 00 A5 .. ; second packet starts 00 01; LFSR continues from packet 1.
REQ-040 clken every 3rd cycle, mode 11 const 5A, len 2 -> usr_data_o stable 5A between accepts; usr_start_o low one cycle after first accept.
REQ-041 reset_i pulsed at byte 2 of len 8 -> all outputs 0 next cycle; clken in IDLE sets err_o=1.
REQ-042 enable_i dropped in SEND of count-0 run -> packet completes at len, then IDLE, busy_o=0.

Source files
------------

// File: rtl/eth_udp_pattern_gen.sv
// UDP payload pattern generator for a PHY user-side byte interface.
// Emits packets of count/LFSR/constant bytes, optionally prefixed with a 16-bit sequence number.
module eth_udp_pattern_gen #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned GAP_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    input  logic [7:0]           const_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [GAP_WIDTH-1:0] gap_i,
    input  logic [CNT_WIDTH-1:0] pkt_count_i,
    input  logic                 seq_hdr_i,
    input  logic                 usr_clken_i,
    output logic                 usr_start_o,
    output logic [7:0]           usr_data_o,
    output logic [LEN_WIDTH-1:0] usr_data_len_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] pkts_sent_o
);

    typedef enum logic [2:0] {StIdle, StStart, StSend, StGap, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           const_q, const_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] pkts_q, pkts_d;
    logic                 seq_hdr_q, seq_hdr_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]          seq_q, seq_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 err_q, err_d;

    logic                 hdr_active;
    logic                 is_hdr_byte;
    logic [LEN_WIDTH-1:0] pat_idx;
    logic [7:0]           pat_byte;
    logic [7:0]           data_byte;
    logic [7:0]           lfsr_next;
    logic [CNT_WIDTH-1:0] pkts_inc;

    always_comb begin
        hdr_active  = seq_hdr_q && (len_q >= LEN_WIDTH'(2));
        is_hdr_byte = hdr_active && (idx_q < LEN_WIDTH'(2));
        pat_idx     = hdr_active ? idx_q - LEN_WIDTH'(2) : idx_q;
        unique case (mode_q)
            2'b00:   pat_byte = pat_idx[7:0];
            2'b01:   pat_byte = cnt_q;
            2'b10:   pat_byte = lfsr_q;
            default: pat_byte = const_q;
        endcase
        if (is_hdr_byte) data_byte = idx_q[0] ? seq_q[7:0] : seq_q[15:8];
        else             data_byte = pat_byte;
        // Fibonacci taps 8,6,5,4 shifting toward the MSB
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pkts_inc  = (&pkts_q) ? pkts_q : pkts_q + CNT_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        const_d     = const_q;
        len_d       = len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_count_d = pkt_count_q;
        pkts_d      = pkts_q;
        seq_hdr_d   = seq_hdr_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (usr_clken_i) err_d = 1'b1;
                if (enable_i && len_i != '0) begin
                    mode_d      = mode_i;
                    const_d     = const_i;
                    len_d       = len_i;
                    gap_d       = gap_i;
                    pkt_count_d = pkt_count_i;
                    seq_hdr_d   = seq_hdr_i;
                    pkts_d      = '0;
                    idx_d       = '0;
                    seq_d       = '0;
                    cnt_d       = '0;
                    lfsr_d      = LFSR_SEED;
                    err_d       = 1'b0;
                    state_d     = StStart;
                end
            end
            StStart, StSend: begin
                if (usr_clken_i) begin
                    state_d = StSend;
                    if (!is_hdr_byte) begin
                        cnt_d  = cnt_q + 8'd1;
                        lfsr_d = lfsr_next;
                    end
                    if (idx_q == len_q - LEN_WIDTH'(1)) begin
                        idx_d  = '0;
                        seq_d  = seq_q + 16'd1;
                        pkts_d = pkts_inc;
                        if (pkt_count_q != '0 && pkts_inc == pkt_count_q) begin
                            state_d = StDone;
                        end else if (!enable_i) begin
                            state_d = StIdle;
                        end else if (gap_q == '0) begin
                            state_d = StStart;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = StGap;
                        end
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            StGap: begin
                if (usr_clken_i) err_d = 1'b1;
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
                    state_d = StStart;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                end
            end
            default: begin
                if (usr_clken_i) err_d = 1'b1;
                if (!enable_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            const_q     <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
            pkts_q      <= '0;
            seq_hdr_q   <= 1'b0;
            idx_q       <= '0;
            seq_q       <= '0;
            cnt_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_count_q <= pkt_count_d;
            pkts_q      <= pkts_d;
            seq_hdr_q   <= seq_hdr_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        usr_start_o    = (state_q == StStart);
        usr_data_o     = (state_q == StStart || state_q == StSend) ? data_byte : 8'h00;
        usr_data_len_o = len_q;
        busy_o         = (state_q == StStart || state_q == StSend || state_q == StGap);
        done_o         = (state_q == StDone);
        err_o          = err_q;
        pkts_sent_o    = pkts_q;
    end

endmodule
